// File: rtl/coinc_win_if.sv
// Bus bundle for coinc_win: single inputs, pair mask, counter clear and all
// coincidence responses and counters.
interface coinc_win_if #(
    parameter int NCH = 4
);
    logic                 en;
    logic [NCH-1:0]       singleA;
    logic [NCH-1:0]       singleB;
    logic [NCH*NCH-1:0]   pairmask;
    logic                 cnt_clr;
    logic [NCH-1:0]       pcoincA;
    logic [NCH-1:0]       ncoincA;
    logic [NCH-1:0]       dcoincA;
    logic [NCH-1:0]       pcoincB;
    logic [NCH-1:0]       ncoincB;
    logic [NCH-1:0]       dcoincB;
    logic [15:0]          npcoinc;
    logic [15:0]          nncoinc;

    modport master (
        output en, singleA, singleB, pairmask, cnt_clr,
        input  pcoincA, ncoincA, dcoincA, pcoincB, ncoincB, dcoincB,
        input  npcoinc, nncoinc
    );

    modport slave (
        input  en, singleA, singleB, pairmask, cnt_clr,
        output pcoincA, ncoincA, dcoincA, pcoincB, ncoincB, dcoincB,
        output npcoinc, nncoinc
    );
endinterface

// File: rtl/coinc_win.sv
// A/B cable coincidence window with prompt/none responses and saturating counters.
// Define COINC_WIN_DCOIN_EN to add the delayed-window (accidental) coincidence path.
module coinc_win #(
    parameter int NCH     = 4,
    parameter int HALFWIN = 1,
    parameter int DLY     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    coinc_win_if.slave bus
);
    localparam int WIN = 2 * HALFWIN + 1;
`ifdef COINC_WIN_DCOIN_EN
    localparam bit DCOIN = 1'b1;
`else
    localparam bit DCOIN = 1'b0;
`endif
    localparam int DEPTH = WIN + (DCOIN ? DLY : 0);

    logic [DEPTH-1:0] sh_a [NCH];
    logic [DEPTH-1:0] sh_b [NCH];
    logic [NCH-1:0]   ctr_a, ctr_b;
    logic [NCH-1:0]   pm_a, pm_b;
    logic [NCH-1:0]   p_a, n_a, p_b, n_b;
    logic [15:0]      np_cnt, nn_cnt;
`ifdef COINC_WIN_DCOIN_EN
    logic [NCH-1:0]   dm_a, dm_b;
    logic [NCH-1:0]   d_a, d_b;
`endif

    function automatic logic [DEPTH-1:0] shift_in(input logic [DEPTH-1:0] r, input logic b);
        logic [DEPTH-1:0] t;
        t    = r << 1;
        t[0] = b;
        return t;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [NCH-1:0] v);
        logic [16:0] s;
        s = {1'b0, c};
        for (int unsigned k = 0; k < NCH; k++) s = s + 17'(v[k]);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                sh_a[i] <= '0;
                sh_b[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                sh_a[i] <= shift_in(sh_a[i], bus.singleA[i] & bus.en);
                sh_b[i] <= shift_in(sh_b[i], bus.singleB[i] & bus.en);
            end
        end
    end

    // A mask bit gates the pair in both directions and for both windows.
    always_comb begin
        ctr_a = '0;
        ctr_b = '0;
        pm_a  = '0;
        pm_b  = '0;
`ifdef COINC_WIN_DCOIN_EN
        dm_a  = '0;
        dm_b  = '0;
`endif
        for (int unsigned i = 0; i < NCH; i++) begin
            ctr_a[i] = sh_a[i][HALFWIN];
            ctr_b[i] = sh_b[i][HALFWIN];
            for (int unsigned j = 0; j < NCH; j++) begin
                if (bus.pairmask[i*NCH + j]) begin
                    pm_a[i] = pm_a[i] | (|sh_b[j][WIN-1:0]);
                    pm_b[j] = pm_b[j] | (|sh_a[i][WIN-1:0]);
`ifdef COINC_WIN_DCOIN_EN
                    dm_a[i] = dm_a[i] | (|sh_b[j][DLY+WIN-1:DLY]);
                    dm_b[j] = dm_b[j] | (|sh_a[i][DLY+WIN-1:DLY]);
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_a <= '0;
            n_a <= '0;
            p_b <= '0;
            n_b <= '0;
`ifdef COINC_WIN_DCOIN_EN
            d_a <= '0;
            d_b <= '0;
`endif
        end else begin
            p_a <= ctr_a & pm_a;
            p_b <= ctr_b & pm_b;
`ifdef COINC_WIN_DCOIN_EN
            d_a <= ctr_a & ~pm_a & dm_a;
            d_b <= ctr_b & ~pm_b & dm_b;
            n_a <= ctr_a & ~pm_a & ~dm_a;
            n_b <= ctr_b & ~pm_b & ~dm_b;
`else
            n_a <= ctr_a & ~pm_a;
            n_b <= ctr_b & ~pm_b;
`endif
        end
    end

    // Clear wins over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            np_cnt <= '0;
            nn_cnt <= '0;
        end else if (bus.cnt_clr) begin
            np_cnt <= '0;
            nn_cnt <= '0;
        end else begin
            np_cnt <= sat_add(np_cnt, p_a);
            nn_cnt <= sat_add(nn_cnt, n_a);
        end
    end

    assign bus.pcoincA = p_a;
    assign bus.ncoincA = n_a;
    assign bus.pcoincB = p_b;
    assign bus.ncoincB = n_b;
`ifdef COINC_WIN_DCOIN_EN
    assign bus.dcoincA = d_a;
    assign bus.dcoincB = d_b;
`else
    assign bus.dcoincA = '0;
    assign bus.dcoincB = '0;
`endif
    assign bus.npcoinc = np_cnt;
    assign bus.nncoinc = nn_cnt;
endmodule

// File: tb/tb_coinc_win.sv
// Directed scoreboard bench for coinc_win; expectations follow COINC_WIN_DCOIN_EN.
module tb_coinc_win;
    localparam int NCH     = 4;
    localparam int HALFWIN = 1;
    localparam int DLY     = 8;
    localparam int LAT     = HALFWIN + 1;
    localparam int PA = 0, NA = 1, DA = 2, PB = 3, NB = 4, DB = 5;
`ifdef COINC_WIN_DCOIN_EN
    localparam int DLY_A = DA;
`else
    localparam int DLY_A = NA;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    coinc_win_if #(.NCH(NCH)) bus ();
    coinc_win #(.NCH(NCH), .HALFWIN(HALFWIN), .DLY(DLY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int             e;
        int             idx;
        logic [NCH-1:0] v;
    } exp_t;

    exp_t           sb[$];
    logic [NCH-1:0] ev [6];
    int n_tests = 0, n_fail = 0, edge_n = 0;
    int exp_np = 0, exp_nn = 0, last_p = 0, last_n = 0;

    function automatic int popc(input logic [NCH-1:0] v);
        int c = 0;
        for (int k = 0; k < NCH; k++) c += int'(v[k]);
        return c;
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed %h expected %h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pcoincA", 16'(bus.pcoincA), 16'(ev[PA]));
        chk("ncoincA", 16'(bus.ncoincA), 16'(ev[NA]));
        chk("dcoincA", 16'(bus.dcoincA), 16'(ev[DA]));
        chk("pcoincB", 16'(bus.pcoincB), 16'(ev[PB]));
        chk("ncoincB", 16'(bus.ncoincB), 16'(ev[NB]));
        chk("dcoincB", 16'(bus.dcoincB), 16'(ev[DB]));
        chk("npcoinc", bus.npcoinc, 16'(exp_np));
        chk("nncoinc", bus.nncoinc, 16'(exp_nn));
    endtask

    task automatic expect_at(input int e, input int idx, input logic [NCH-1:0] v);
        exp_t x;
        x.e = e; x.idx = idx; x.v = v;
        sb.push_back(x);
    endtask

    // Expect a response for a single sampled at the coming edge.
    task automatic expect_next(input int idx, input logic [NCH-1:0] v);
        expect_at(edge_n + 1 + LAT, idx, v);
    endtask

    task automatic tick();
        logic clr, rst_pre;
        int   i;
        clr     = bus.cnt_clr;
        rst_pre = rst_n;
        @(posedge clk);
        #1;
        edge_n++;
        for (int k = 0; k < 6; k++) ev[k] = '0;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].e == edge_n) begin
                ev[sb[i].idx] = ev[sb[i].idx] | sb[i].v;
                sb.delete(i);
            end else begin
                i++;
            end
        end
        if (!rst_pre || clr) begin
            exp_np = 0;
            exp_nn = 0;
        end else begin
            exp_np = sat16(exp_np + last_p);
            exp_nn = sat16(exp_nn + last_n);
        end
        last_p = popc(ev[PA]);
        last_n = popc(ev[NA]);
        check_all();
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        sb.delete();
        exp_np = 0; exp_nn = 0; last_p = 0; last_n = 0;
        for (int k = 0; k < 6; k++) ev[k] = '0;
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        bus.en       = 1'b1;
        bus.singleA  = '0;
        bus.singleB  = '0;
        bus.pairmask = '1;
        bus.cnt_clr  = 1'b0;
        rst_n        = 1'b0;
        for (int k = 0; k < 6; k++) ev[k] = '0;
        #2;
        check_all();
        idle(2);
        rst_n = 1'b1;
        idle(3);

        // Prompt pair: A[0] then B[2] one clock later
        bus.singleA = 4'b0001; expect_next(PA, 4'b0001); tick();
        bus.singleA = '0; bus.singleB = 4'b0100; expect_next(PB, 4'b0100); tick();
        bus.singleB = '0; idle(20);

        // Lone A[1]
        bus.singleA = 4'b0010; expect_next(NA, 4'b0010); tick();
        bus.singleA = '0; idle(20);

        // B[3] then A[0] DLY clocks later
        bus.singleB = 4'b1000; expect_next(NB, 4'b1000); tick();
        bus.singleB = '0; idle(DLY - 1);
        bus.singleA = 4'b0001; expect_next(DLY_A, 4'b0001); tick();
        bus.singleA = '0; idle(20);

        // Delayed window edges: offsets DLY-1 and DLY+1 inside, DLY+2 outside
        bus.singleB = 4'b0100; expect_next(NB, 4'b0100); tick();
        bus.singleB = '0; idle(DLY - HALFWIN - 1);
        bus.singleA = 4'b0100; expect_next(DLY_A, 4'b0100); tick();
        bus.singleA = '0; tick();
        bus.singleA = 4'b0010; expect_next(DLY_A, 4'b0010); tick();
        bus.singleA = 4'b0100; expect_next(NA, 4'b0100); tick();
        bus.singleA = '0; idle(20);

        // Pair A[0]/B[2] masked off: prompt and delayed both excluded
        bus.pairmask = 16'hFFFB;
        bus.singleA = 4'b0001; expect_next(NA, 4'b0001); tick();
        bus.singleA = '0; bus.singleB = 4'b0100; expect_next(NB, 4'b0100); tick();
        bus.singleB = '0; idle(20);
        bus.singleB = 4'b0100; expect_next(NB, 4'b0100); tick();
        bus.singleB = '0; idle(DLY - 1);
        bus.singleA = 4'b0001; expect_next(NA, 4'b0001); tick();
        bus.singleA = '0; idle(20);
        bus.pairmask = '1;

        // One B single serves two A channels and two back-to-back A singles
        bus.singleA = 4'b1001; bus.singleB = 4'b0001;
        expect_next(PA, 4'b1001); expect_next(PB, 4'b0001); tick();
        bus.singleB = '0; expect_next(PA, 4'b1001); tick();
        bus.singleA = '0; idle(20);

        // Prompt window edge: B two clocks after A is outside
        bus.singleA = 4'b0010; expect_next(NA, 4'b0010); tick();
        bus.singleA = '0; tick();
        bus.singleB = 4'b0010; expect_next(NB, 4'b0010); tick();
        bus.singleB = '0; idle(20);

        // en falls after A[0] is sampled: A completes, gated B is ignored
        bus.singleA = 4'b0001; expect_next(NA, 4'b0001); tick();
        bus.singleA = '0; bus.en = 1'b0; bus.singleB = 4'b0001; tick();
        bus.singleB = '0; idle(4);
        bus.en = 1'b1; idle(20);

        // Reset while an event is in flight: no response, counters zero
        bus.singleA = 4'b0001; tick();
        bus.singleA = '0;
        assert_reset();
        idle(2);
        rst_n = 1'b1;
        idle(20);

        // Saturation of npcoinc with A all and B[0] held every clock
        bus.singleA = '1; bus.singleB = 4'b0001;
        for (int k = 0; k < 16400; k++) begin
            expect_next(PA, 4'b1111); expect_next(PB, 4'b0001); tick();
        end
        chk("npcoinc_sat", bus.npcoinc, 16'hFFFF);
        bus.cnt_clr = 1'b1;
        expect_next(PA, 4'b1111); expect_next(PB, 4'b0001); tick();
        chk("npcoinc_clr", bus.npcoinc, 16'h0000);
        bus.cnt_clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect_next(PA, 4'b1111); expect_next(PB, 4'b0001); tick();
        end
        chk("npcoinc_after_clr", bus.npcoinc, 16'd16);
        bus.singleA = '0; bus.singleB = '0;
        idle(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/coinc_win.md
COINC_WIN -- requirements
Module: coinc_win

Interface
REQ-001 Parameter NCH, default 4: cable channels per side (A and B); legal range 1..8.
REQ-002 Parameter HALFWIN, default 1: coincidence half-window in clocks; legal range 0..7.
REQ-003 Parameter DLY, default 8: delayed-window offset in clocks; SHALL satisfy DLY > 2*HALFWIN.
REQ-004 Ports SHALL be as follows:
- clk  in  1  100 MHz system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  1 = accept singles, 0 = treat all singles as 0.
- singleA  in  NCH  per-channel single trigger, A side.
- singleB  in  NCH  per-channel single trigger, B side.
- pairmask  in  NCH*NCH  bit i*NCH+j enables pairing A[i] with B[j]; quasi-static.
- cnt_clr  in  1  synchronous clear of both counters.
- pcoincA, ncoincA, dcoincA  out  NCH each  prompt / none / delayed response, A side.
- pcoincB, ncoincB, dcoincB  out  NCH each  prompt / none / delayed response, B side.
- npcoinc  out  16  saturating count of A-side prompt responses.
- nncoinc  out  16  saturating count of A-side none responses.

Function
REQ-005 Each single input SHALL feed its own shift register, sampled every clk edge; the sampled value is single AND en.
REQ-006 Tap k of a shift register SHALL hold the sample taken k+1 edges earlier. The centre tap is HALFWIN.
REQ-007 The prompt window for a centre event SHALL be taps 0..2*HALFWIN, i.e. an offset of -HALFWIN..+HALFWIN clocks.
REQ-008 A[i] has a prompt match when any B[j] with pairmask[i*NCH+j]=1 has a 1 in its prompt window; B[j] is symmetric using the same mask bit.
REQ-009 When A[i]'s centre tap is 1, exactly one of pcoincA[i], dcoincA[i], ncoincA[i] SHALL be 1 for one cycle.
REQ-010 The response of REQ-009 SHALL be registered at the edge HALFWIN+1 clocks after the edge that sampled the single.
REQ-011 Response priority SHALL be prompt, then delayed, then none.
REQ-012 When the centre tap is 0, all three outputs for that channel SHALL be 0.
REQ-013 Back-to-back singles on one channel SHALL each produce an independent response on consecutive cycles.
REQ-014 One B single SHALL be able to satisfy several A channels and several A singles; no match is consumed.
REQ-015 npcoinc and nncoinc SHALL each add the popcount of pcoincA and ncoincA respectively every cycle.
REQ-016 Both counters SHALL saturate at 16'hFFFF; the saturated value is held, not wrapped.
REQ-017 cnt_clr SHALL zero both counters; when cnt_clr and an increment coincide, the result SHALL be 0.
REQ-018 A pairmask bit of 0 SHALL exclude that pair from both the prompt and the delayed match.
REQ-019 en SHALL gate only new samples; events already in the shift registers complete normally after en falls.

Reset
REQ-020 While rst_n=0, all shift registers, all coinc outputs and both counters SHALL be 0, asynchronously.
REQ-021 An event in flight when reset asserts SHALL be discarded with no response; no spurious response SHALL follow deassertion.
REQ-022 The first sample after reset release SHALL be taken at the first clk edge with rst_n=1.

Configuration
REQ-023 With macro COINC_WIN_DCOIN_EN defined:
- shift register depth is 2*HALFWIN+1+DLY;
- the delayed window for a centre event is taps HALFWIN+DLY-HALFWIN .. HALFWIN+DLY+HALFWIN of the partner side, i.e. the partner fired DLY clocks earlier, +/-HALFWIN;
- a delayed match without a prompt match drives dcoinc.
REQ-024 Without COINC_WIN_DCOIN_EN:
- the depth is 2*HALFWIN+1 and no delay taps exist;
- dcoincA and dcoincB are constant 0;
- an event with no prompt match drives ncoinc.

Verification (NCH=4, HALFWIN=1, DLY=8, pairmask all 1, en=1, macro defined unless noted)
REQ-025 singleA=4'b0001 one cycle at edge 10, singleB=4'b0100 at edge 11 -> pcoincA[0]=1 and pcoincB[2]=1, registered at edges 12 and 13 respectively; npcoinc=1.
REQ-026 singleA[1] at edge 20, no B activity -> ncoincA[1]=1 at edge 22; nncoinc=1; all other outputs 0.
REQ-027 singleB[3] at edge 30, singleA[0] at edge 38 -> dcoincA[0]=1 at edge 40 and ncoincB[3]=1 at edge 32; with the macro undefined, ncoincA[0]=1 at edge 40 instead.
REQ-028 Same as REQ-025 with pairmask bit 0*4+2 cleared -> ncoincA[0] and ncoincB[2] instead of prompt responses.
REQ-029 singleA=4'b1111 held every cycle with singleB[0] held -> npcoinc reaches 16'hFFFF and holds; cnt_clr pulse -> npcoinc=0 on the next edge, increments thereafter.
REQ-030 singleA[0] at edge 50, rst_n low from edge 51 to edge 53 -> no response on any output; counters read 0 after release.
